// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes, FSM states, default iteration count.
package muldiv_pkg;

    localparam int DEFAULT_ITER = 32;

    localparam logic [4:0] OP_MULT  = 5'b01100;
    localparam logic [4:0] OP_MULTU = 5'b01101;
    localparam logic [4:0] OP_DIV   = 5'b01110;
    localparam logic [4:0] OP_DIVU  = 5'b01111;
    localparam logic [4:0] OP_MTHI  = 5'b01001;
    localparam logic [4:0] OP_MTLO  = 5'b01011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One combinational step: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_iter (
    input  logic        is_mul,
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] operand,
    output logic [31:0] nxt_hi,
    output logic [31:0] nxt_lo
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        ge;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
        shifted = {acc_hi, acc_lo[31]};
        // A set carry-out bit means the partial remainder already exceeds any 32-bit divisor.
        ge      = shifted[32] || (shifted[31:0] >= operand);
        diff    = shifted[31:0] - operand;
        nxt_hi  = shifted[31:0];
        nxt_lo  = {acc_lo[30:0], 1'b0};
        if (is_mul) begin
            nxt_hi = sum[32:1];
            nxt_lo = {sum[0], acc_lo[31:1]};
        end else if (ge) begin
            nxt_hi = diff;
            nxt_lo = {acc_lo[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit; works on operand magnitudes and fixes signs on the last step.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = DEFAULT_ITER
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [4:0]  aluop,
    input  logic [31:0] aluA,
    input  logic [31:0] aluB,
    output logic [31:0] hiOut,
    output logic [31:0] loOut,
    output logic        finish,
    output logic        busy,
    output state_t      dbg_state
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_mul_q, neg_res_q, neg_rem_q, dbz_q;
    logic [31:0]        a_raw_q, b_q, acc_hi_q, acc_lo_q;
    logic [31:0]        hi_q, lo_q;

    logic               accept, last, op_signed;
    logic [31:0]        a_mag, b_mag, step_hi, step_lo;
    logic [31:0]        res_hi, res_lo;
    logic [63:0]        prod;

    assign accept    = (state_q == S_IDLE) && start && is_muldiv(aluop);
    assign last      = (state_q == S_BUSY) && (cnt_q == CNT_W'(ITER - 1));
    assign op_signed = (aluop == OP_MULT) || (aluop == OP_DIV);
    assign a_mag     = (op_signed && aluA[31]) ? (32'd0 - aluA) : aluA;
    assign b_mag     = (op_signed && aluB[31]) ? (32'd0 - aluB) : aluB;

    assign hiOut     = hi_q;
    assign loOut     = lo_q;
    assign finish    = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign dbg_state = state_q;

    muldiv_iter u_iter (
        .is_mul  (is_mul_q),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (b_q),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BUSY;
            S_BUSY:  if (last)   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sign correction applied to the final step's result as it is written to HI/LO.
    always_comb begin
        prod   = {step_hi, step_lo};
        if (neg_res_q) prod = 64'd0 - prod;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (!is_mul_q) begin
            if (dbz_q) begin
                res_hi = a_raw_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_lo = neg_res_q ? (32'd0 - step_lo) : step_lo;
                res_hi = neg_rem_q ? (32'd0 - step_hi) : step_hi;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            is_mul_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            a_raw_q   <= '0;
            b_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (accept) begin
                cnt_q     <= '0;
                is_mul_q  <= (aluop == OP_MULT) || (aluop == OP_MULTU);
                neg_res_q <= op_signed && (aluA[31] ^ aluB[31]);
                neg_rem_q <= op_signed && aluA[31];
                dbz_q     <= (aluB == 32'd0);
                a_raw_q   <= aluA;
                b_q       <= b_mag;
                acc_hi_q  <= '0;
                acc_lo_q  <= a_mag;
            end
            if (state_q == S_BUSY) begin
                acc_hi_q <= step_hi;
                acc_lo_q <= step_lo;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end
            if (state_q == S_IDLE) begin
                if (aluop == OP_MTHI) hi_q <= aluA;
                if (aluop == OP_MTLO) lo_q <= aluA;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic reference model of HI/LO results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  aluop = 5'd0;
    logic [31:0] aluA = '0;
    logic [31:0] aluB = '0;
    logic [31:0] hiOut, loOut;
    logic        finish, busy;
    state_t      dbg_state;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;
    logic [4:0]  op_tab[6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    muldiv_unit #(.ITER(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .aluop     (aluop),
        .aluA      (aluA),
        .aluB      (aluB),
        .hiOut     (hiOut),
        .loOut     (loOut),
        .finish    (finish),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: plain 64-bit arithmetic, SV division truncates toward zero
    function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q, m;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            OP_MULT:  r = sa * sb;
            OP_MULTU: r = ua * ub;
            OP_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // driver tasks
    task automatic quiet();
        start = 1'b0;
        aluop = 5'd0;
        aluA  = '0;
        aluB  = '0;
    endtask

    task automatic junk();
        start = 1'($urandom_range(0, 1));
        aluop = ($urandom_range(0, 7) < 6) ? op_tab[$urandom_range(0, 5)] : 5'($urandom);
        aluA  = $urandom;
        aluB  = $urandom;
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the DONE cycle.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int          cycles;
        logic [63:0] e;
        exp_q.push_back(ref_model(op, a, b));
        start = 1'b1;
        aluop = op;
        aluA  = a;
        aluB  = b;
        @(negedge CLK);
        check("busy_after_accept", busy, 1'b1);
        start = 1'b0;
        aluop = OP_MTLO;
        aluA  = 32'hDEAD_BEEF;
        @(negedge CLK);
        check("mtlo_in_busy", loOut, cur_lo);
        cycles = 2;
        junk();
        while (!finish && cycles < 40) begin
            @(negedge CLK);
            cycles++;
            junk();
        end
        check("latency", cycles, 33);
        e = exp_q.pop_front();
        check($sformatf("hi op=%b a=%h b=%h", op, a, b), hiOut, e[63:32]);
        check($sformatf("lo op=%b a=%h b=%h", op, a, b), loOut, e[31:0]);
        cur_hi = e[63:32];
        cur_lo = e[31:0];
    endtask

    initial begin
        int fin_seen;
        quiet();
        repeat (3) @(negedge CLK);
        check("rst_hi", hiOut, 32'd0);
        check("rst_lo", loOut, 32'd0);
        check("rst_finish", finish, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, S_IDLE);

        // start presented together with reset release is accepted on the next edge
        RST_N = 1'b1;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        @(negedge CLK);
        check("finish_one_cycle", finish, 1'b0);
        check("idle_after_done", dbg_state, S_IDLE);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        @(negedge CLK);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        @(negedge CLK);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge CLK);
        run_op(OP_DIVU, 32'd7, 32'd0);
        @(negedge CLK);
        run_op(OP_DIV, 32'h8000_0005, 32'd0);

        @(negedge CLK);
        start = 1'b0;
        aluop = OP_MTHI;
        aluA  = 32'h0000_1234;
        @(negedge CLK);
        check("mthi_hi", hiOut, 32'h0000_1234);
        check("mthi_lo_kept", loOut, cur_lo);
        cur_hi = 32'h0000_1234;
        aluop = OP_MTLO;
        aluA  = 32'h0000_5678;
        @(negedge CLK);
        check("mtlo_lo", loOut, 32'h0000_5678);
        check("mtlo_hi_kept", hiOut, cur_hi);
        cur_lo = 32'h0000_5678;
        start = 1'b1;
        aluop = 5'b00010;
        @(negedge CLK);
        check("bad_op_ignored", busy, 1'b0);
        check("bad_op_hi", hiOut, cur_hi);
        check("bad_op_lo", loOut, cur_lo);
        quiet();

        // reset in the middle of a multiply discards it
        @(negedge CLK);
        start = 1'b1;
        aluop = OP_MULT;
        aluA  = 32'h0001_0003;
        aluB  = 32'h0000_0777;
        @(negedge CLK);
        quiet();
        repeat (9) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_finish", finish, 1'b0);
        check("midrst_hi", hiOut, 32'd0);
        check("midrst_lo", loOut, 32'd0);
        check("midrst_state", dbg_state, S_IDLE);
        cur_hi = '0;
        cur_lo = '0;
        fin_seen = 0;
        repeat (3) begin
            @(negedge CLK);
            if (finish) fin_seen++;
        end
        RST_N = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            if (finish) fin_seen++;
        end
        check("no_finish_after_rst", fin_seen, 0);

        repeat (20) begin
            @(negedge CLK);
            run_op(op_tab[$urandom_range(0, 3)], pick_operand(), pick_operand());
        end

        @(negedge CLK);
        quiet();
        @(negedge CLK);
        check("final_hi_hold", hiOut, cur_hi);
        check("final_lo_hold", loOut, cur_lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter ITER, default 32, SHALL set the iteration count for multiply and divide.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be the level request from the ALU stage; it is sampled only in IDLE.
REQ-005 aluop  input  5  SHALL select the operation: 01100 mult, 01101 multu, 01110 div, 01111 divu, 01001 mthi, 01011 mtlo.
REQ-006 aluA  input  32  SHALL be operand A (multiplicand/dividend, or mthi/mtlo source).
REQ-007 aluB  input  32  SHALL be operand B (multiplier/divisor).
REQ-008 hiOut  output  32  SHALL be the architectural HI register.
REQ-009 loOut  output  32  SHALL be the architectural LO register.
REQ-010 finish  output  1  SHALL be high for exactly the one cycle in which state is DONE.
REQ-011 busy  output  1  SHALL be high while state is BUSY.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-013 In IDLE, start=1 with aluop in {mult, multu, div, divu} SHALL capture the operands, opcode and sign flags, clear the iteration counter and enter BUSY on that edge (the acceptance edge).
REQ-014 In IDLE, start=1 with any other aluop SHALL be ignored.
REQ-015 In BUSY, the unit SHALL perform one shift-add (mul) or one restoring shift-subtract (div) step per cycle.
REQ-016 BUSY SHALL last exactly ITER cycles.
REQ-017 On the edge leaving BUSY, the unit SHALL write hiOut/loOut and enter DONE, so finish is high in the 33rd cycle after the acceptance edge (ITER=32).
REQ-018 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-019 A start=1 presented in the cycle after DONE SHALL be accepted as a new operation, so back-to-back mul/div is supported.
REQ-020 start and aluop SHALL be ignored during BUSY and DONE; an accepted operation always completes.
REQ-021 mult/multu SHALL produce the full 64-bit product {hi,lo}, with signed or unsigned interpretation per opcode.
REQ-022 Signed div SHALL divide magnitudes, then negate the quotient (lo) if the operand signs differ and give the remainder (hi) the sign of the dividend.
REQ-023 Divide by zero SHALL take the normal latency and yield lo=FFFFFFFF, hi=aluA, for both signed and unsigned div.
REQ-024 Signed 80000000/FFFFFFFF SHALL yield lo=80000000, hi=00000000.
REQ-025 In IDLE, aluop=mthi SHALL load hiOut=aluA, and aluop=mtlo SHALL load loOut=aluA, on the next edge; start is not required.
REQ-026 mthi/mtlo SHALL be ignored outside IDLE.
REQ-027 hiOut/loOut SHALL hold their values at all other times.

Reset
REQ-028 RST_N=0 SHALL immediately force state IDLE, hiOut=0, loOut=0, finish=0, busy=0 and counter=0, including in the middle of an operation; the in-flight operation is discarded.
REQ-029 After RST_N rises, the first start SHALL be accepted on the next edge.

Structure
REQ-030 Package muldiv_pkg SHALL hold the aluop encodings, the state enum and the default ITER.
REQ-031 Sub-module muldiv_iter SHALL implement one combinational step (add-or-pass for mul, trial-subtract for div), instantiated once.
REQ-032 Operand, product and remainder registers SHALL reside in muldiv_unit.

Verification
REQ-033 Scenario: mult A=FFFFFFFD (-3), B=7 -> 33 cycles after acceptance finish=1 for one cycle, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-034 Scenario: multu A=FFFFFFFF, B=2 -> hi=00000001, lo=FFFFFFFE.
REQ-035 Scenario: div A=FFFFFFF9 (-7), B=2 -> lo=FFFFFFFD, hi=FFFFFFFF; then div 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-036 Scenario: divu A=7, B=0 -> lo=FFFFFFFF, hi=00000007 at normal latency.
REQ-037 Scenario: mthi A=1234 in IDLE -> hiOut=00001234 next edge; mtlo issued during BUSY -> loOut unchanged.
REQ-038 Scenario: RST_N low 10 cycles into a mult, and a second mult with start=1 in the cycle after DONE -> reset gives immediate IDLE, hi=lo=0, finish never pulses; the back-to-back case is accepted immediately and finishes 33 cycles later.
